// File: rtl/boot_host_pkg.sv
// Shared definitions for the host-side boot server: state codes, default sync
// bytes and the image size helper.
package boot_host_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_PROG = 3'd1;
    localparam state_t ST_SEND_SIZE = 3'd2;
    localparam state_t ST_SEND_PROG = 3'd3;
    localparam state_t ST_WAIT_DATA = 3'd4;
    localparam state_t ST_SEND_DATA = 3'd5;
    localparam state_t ST_DONE      = 3'd6;

    localparam logic [7:0] SYNC_PROG_DEFAULT = 8'h99;
    localparam logic [7:0] SYNC_DATA_DEFAULT = 8'haa;

    // the program size header is always a 32-bit count, whatever the word size
    localparam int SIZE_BYTES = 4;

    function automatic logic [31:0] byte_count(input logic [31:0] len_words,
                                               input int unsigned word_bytes);
        return len_words * 32'(word_bytes);
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Emits up to MAX_BYTES bytes of a loaded word LSB first, spacing tx_start
// pulses so a UartTx that raises tx_busy one cycle late is never overrun.
module word_serializer #(
    parameter int MAX_BYTES = 4,
    localparam int NW = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [8*MAX_BYTES-1:0] word,
    input  logic [NW-1:0]          nbytes,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             sdata,
    output logic                   last_byte
);

    logic [8*MAX_BYTES-1:0] shift;
    logic [NW-1:0]          left;
    logic                   active;
    logic                   tx_start_d1;
    logic                   fire;

    // two quiet cycles after every pulse before tx_busy is trusted again
    assign fire = active && !tx_busy && !tx_start && !tx_start_d1;

    always_ff @(posedge clock) begin
        if (reset) begin
            shift       <= '0;
            left        <= '0;
            active      <= 1'b0;
            tx_start    <= 1'b0;
            tx_start_d1 <= 1'b0;
            sdata       <= 8'h00;
            last_byte   <= 1'b0;
        end else begin
            tx_start    <= fire;
            tx_start_d1 <= tx_start;
            last_byte   <= fire && (left == NW'(1));
            if (load) begin
                shift  <= word;
                left   <= nbytes;
                active <= (nbytes != '0);
            end else if (fire) begin
                sdata <= shift[7:0];
                shift <= shift >> 8;
                left  <= left - NW'(1);
                if (left == NW'(1))
                    active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/boot_host.sv
// Host-side boot server: serves a program image and a data image over the UART
// loader protocol and forwards every byte the CPU returns as a result stream.
//
// state      | meaning
// IDLE       | buffers writable, waiting for start
// WAIT_PROG  | waiting for SYNC_PROG from the CPU
// SEND_SIZE  | sending the 32-bit program byte count
// SEND_PROG  | sending program words
// WAIT_DATA  | waiting for SYNC_DATA from the CPU
// SEND_DATA  | sending data words, forwarding results
// DONE       | forwarding results, start re-runs the session
module boot_host
    import boot_host_pkg::*;
#(
    parameter int         WORD_BYTES  = 4,
    parameter int         INSTR_DEPTH = 256,
    parameter int         DATA_DEPTH  = 256,
    parameter logic [7:0] SYNC_PROG   = SYNC_PROG_DEFAULT,
    parameter logic [7:0] SYNC_DATA   = SYNC_DATA_DEFAULT,
    localparam int AW = $clog2((INSTR_DEPTH > DATA_DEPTH) ? INSTR_DEPTH : DATA_DEPTH),
    localparam int IL = $clog2(INSTR_DEPTH) + 1,
    localparam int DL = $clog2(DATA_DEPTH) + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_en,
    input  logic                    load_sel,
    input  logic [AW-1:0]           load_addr,
    input  logic [8*WORD_BYTES-1:0] load_data,
    input  logic [IL-1:0]           instr_len,
    input  logic [DL-1:0]           data_len,
    input  logic                    start,
    output logic                    tx_start,
    output logic [7:0]              sdata,
    input  logic                    tx_busy,
    input  logic                    rx_ready,
    input  logic [7:0]              rdata,
    input  logic                    ferr,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    res_valid,
    output logic [7:0]              res_data,
    output logic [31:0]             res_count
);

    localparam int IAW = $clog2(INSTR_DEPTH);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int CW  = AW + 1;
    localparam int WW  = 8 * WORD_BYTES;
    localparam int SB  = (WORD_BYTES > SIZE_BYTES) ? WORD_BYTES : SIZE_BYTES;
    localparam int NW  = $clog2(SB + 1);

    logic [WW-1:0]   prog_mem [INSTR_DEPTH];
    logic [WW-1:0]   data_mem [DATA_DEPTH];
    logic [WW-1:0]   prog_q;
    logic [WW-1:0]   data_q;

    state_t          state;
    logic [CW-1:0]   ilen;
    logic [CW-1:0]   dlen;
    logic [CW-1:0]   wcnt;
    logic [CW-1:0]   cur_len;
    logic [1:0]      ph;
    logic            ser_load;
    logic [8*SB-1:0] ser_word;
    logic [NW-1:0]   ser_nbytes;
    logic            last_byte;
    logic            rx_good;
    logic [31:0]     size_bytes;

    assign rx_good    = rx_ready && !ferr;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign cur_len    = (state == ST_SEND_PROG) ? ilen : dlen;
    assign size_bytes = byte_count(32'(ilen), WORD_BYTES);

    // buffers: write port only in IDLE, registered read indexed by the word counter
    always_ff @(posedge clock) begin
        prog_q <= prog_mem[wcnt[IAW-1:0]];
        data_q <= data_mem[wcnt[DAW-1:0]];
        if (state == ST_IDLE && load_en) begin
            if (!load_sel && ({1'b0, load_addr} < (AW+1)'(INSTR_DEPTH)))
                prog_mem[load_addr[IAW-1:0]] <= load_data;
            if (load_sel && ({1'b0, load_addr} < (AW+1)'(DATA_DEPTH)))
                data_mem[load_addr[DAW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            ilen       <= '0;
            dlen       <= '0;
            wcnt       <= '0;
            ph         <= 2'd0;
            ser_load   <= 1'b0;
            ser_word   <= '0;
            ser_nbytes <= '0;
            err        <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= 8'h00;
            res_count  <= 32'd0;
        end else begin
            ser_load  <= 1'b0;
            res_valid <= 1'b0;
            if (rx_good && (state == ST_SEND_DATA || state == ST_DONE)) begin
                res_valid <= 1'b1;
                res_data  <= rdata;
                if (res_count != 32'hFFFF_FFFF)
                    res_count <= res_count + 32'd1;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        ilen      <= (instr_len > IL'(INSTR_DEPTH)) ? CW'(INSTR_DEPTH) : CW'(instr_len);
                        dlen      <= (data_len > DL'(DATA_DEPTH)) ? CW'(DATA_DEPTH) : CW'(data_len);
                        err       <= 1'b0;
                        res_count <= 32'd0;
                        state     <= ST_WAIT_PROG;
                    end
                end
                ST_WAIT_PROG: begin
                    if (rx_good && rdata == SYNC_PROG) begin
                        ser_load   <= 1'b1;
                        ser_word   <= (8*SB)'(size_bytes);
                        ser_nbytes <= NW'(SIZE_BYTES);
                        state      <= ST_SEND_SIZE;
                    end
                end
                ST_SEND_SIZE: begin
                    if (last_byte) begin
                        wcnt  <= '0;
                        ph    <= 2'd0;
                        state <= (ilen == '0) ? ST_WAIT_DATA : ST_SEND_PROG;
                    end
                end
                ST_SEND_PROG, ST_SEND_DATA: begin
                    // ph 0: read address settles, ph 1: word valid, ph 2: draining bytes
                    case (ph)
                        2'd0: ph <= 2'd1;
                        2'd1: begin
                            ser_load   <= 1'b1;
                            ser_word   <= (8*SB)'((state == ST_SEND_PROG) ? prog_q : data_q);
                            ser_nbytes <= NW'(WORD_BYTES);
                            ph         <= 2'd2;
                        end
                        2'd2: begin
                            if (last_byte) begin
                                wcnt <= wcnt + CW'(1);
                                ph   <= 2'd0;
                                if (wcnt + CW'(1) == cur_len)
                                    state <= (state == ST_SEND_PROG) ? ST_WAIT_DATA : ST_DONE;
                            end
                        end
                        default: ph <= 2'd0;
                    endcase
                end
                ST_WAIT_DATA: begin
                    if (rx_good && rdata == SYNC_DATA) begin
                        wcnt  <= '0;
                        ph    <= 2'd0;
                        state <= (dlen == '0) ? ST_DONE : ST_SEND_DATA;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (rx_ready && ferr)
                err <= 1'b1;
        end
    end

    word_serializer #(.MAX_BYTES(SB)) u_ser (
        .clock     (clock),
        .reset     (reset),
        .load      (ser_load),
        .word      (ser_word),
        .nbytes    (ser_nbytes),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .sdata     (sdata),
        .last_byte (last_byte)
    );

endmodule

// File: tb/tb_boot_host.sv
// Bench for boot_host: a UART-side model answers tx_start with a randomly late
// tx_busy, and byte streams are checked against images kept in the bench.
module tb_boot_host;

    logic        clock;
    logic        reset;
    logic        load_en;
    logic        load_sel;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [8:0]  instr_len;
    logic [8:0]  data_len;
    logic        start;
    logic        tx_start;
    logic [7:0]  sdata;
    logic        tx_busy;
    logic        rx_ready;
    logic [7:0]  rdata;
    logic        ferr;
    logic        busy;
    logic        done;
    logic        err;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [31:0] res_count;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] prog_m [256];
    logic [31:0] data_m [256];
    logic [7:0]  tx_q [$];
    logic [7:0]  res_q [$];
    bit          uart_active;
    int          pre_cnt;
    int          rem_cnt;

    boot_host dut (
        .clock     (clock),
        .reset     (reset),
        .load_en   (load_en),
        .load_sel  (load_sel),
        .load_addr (load_addr),
        .load_data (load_data),
        .instr_len (instr_len),
        .data_len  (data_len),
        .start     (start),
        .tx_start  (tx_start),
        .sdata     (sdata),
        .tx_busy   (tx_busy),
        .rx_ready  (rx_ready),
        .rdata     (rdata),
        .ferr      (ferr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_count (res_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART side: tx_busy rises 0 or 1 cycles after each pulse and holds 3..8 cycles
    initial begin
        tx_busy = 1'b0;
        uart_active = 1'b0;
        pre_cnt = 0;
        rem_cnt = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                tx_busy = 1'b0;
                uart_active = 1'b0;
            end else begin
                if (tx_start) begin
                    chk("tx_start_while_uart_busy", {31'd0, uart_active}, 32'd0);
                    tx_q.push_back(sdata);
                    uart_active = 1'b1;
                    pre_cnt = $urandom_range(0, 1);
                    rem_cnt = $urandom_range(3, 8);
                end
                if (uart_active) begin
                    if (pre_cnt > 0) pre_cnt--;
                    else if (rem_cnt > 0) begin
                        tx_busy = 1'b1;
                        rem_cnt--;
                    end else begin
                        tx_busy = 1'b0;
                        uart_active = 1'b0;
                    end
                end
                if (res_valid) res_q.push_back(res_data);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic load_word(input bit sel, input int addr, input logic [31:0] d);
        load_en = 1'b1;
        load_sel = sel;
        load_addr = 8'(addr);
        load_data = d;
        tick(1);
        load_en = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit fe);
        rx_ready = 1'b1;
        rdata = b;
        ferr = fe;
        tick(1);
        rx_ready = 1'b0;
        ferr = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k = 0;
        while (tx_q.size() < n && k < 20 * n + 50) begin
            tick(1);
            k++;
        end
        chk(tag, tx_q.size(), n);
    endtask

    task automatic cmp_stream(input string tag, input logic [7:0] exp[$]);
        for (int i = 0; i < exp.size(); i++)
            if (i < tx_q.size()) chk(tag, tx_q[i], exp[i]);
    endtask

    task automatic run_session(input int il, input int dl, input bit noise,
                               input logic [7:0] r0, input logic [7:0] r1);
        int el = (il > 256) ? 256 : il;
        int ed = (dl > 256) ? 256 : dl;
        int lat;
        int k;
        logic [7:0] exp_tx[$];
        logic [7:0] exp_res[$];
        logic [31:0] sz;

        instr_len = 9'(il);
        data_len = 9'(dl);
        res_q.delete();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tx_q.delete();
        tick(1);
        chk("after_start_busy", busy, 1);
        chk("after_start_done", done, 0);
        chk("after_start_err", err, 0);
        chk("after_start_res_count", res_count, 0);

        if (noise) begin
            send_rx(8'h55, 1'b0);
            tick(8);
            chk("noise_no_tx", tx_q.size(), 0);
            send_rx(8'h99, 1'b1);
            tick(8);
            chk("ferr_sets_err", err, 1);
            chk("ferr_byte_dropped", tx_q.size(), 0);
            chk("wait_prog_still_busy", busy, 1);
        end

        rx_ready = 1'b1;
        rdata = 8'h99;
        ferr = 1'b0;
        tick(1);
        rx_ready = 1'b0;
        lat = 1;
        while (!tx_start && lat < 10) begin
            tick(1);
            lat++;
        end
        chk("first_tx_within_3", {31'd0, lat <= 3}, 1);

        sz = 32'(el) * 32'd4;
        for (int b = 0; b < 4; b++) exp_tx.push_back(sz[8*b +: 8]);
        for (int w = 0; w < el; w++)
            for (int b = 0; b < 4; b++) exp_tx.push_back(prog_m[w][8*b +: 8]);
        wait_tx(exp_tx.size(), "prog_byte_count");
        tick(30);
        chk("no_tx_before_data_sync", tx_q.size(), exp_tx.size());
        cmp_stream("prog_byte", exp_tx);
        chk("wait_data_done", done, 0);
        tx_q.delete();
        exp_tx.delete();

        send_rx(8'haa, 1'b0);
        if (ed > 0) begin
            send_rx(r0, 1'b0);
            exp_res.push_back(r0);
        end
        for (int w = 0; w < ed; w++)
            for (int b = 0; b < 4; b++) exp_tx.push_back(data_m[w][8*b +: 8]);
        wait_tx(exp_tx.size(), "data_byte_count");
        cmp_stream("data_byte", exp_tx);
        k = 0;
        while (!done && k < 40) begin
            tick(1);
            k++;
        end
        chk("reached_done", done, 1);

        send_rx(8'($urandom), 1'b1);
        send_rx(r1, 1'b0);
        exp_res.push_back(r1);
        if (ed == 0) begin
            send_rx(r0, 1'b0);
            exp_res.push_back(r0);
        end
        tick(3);
        chk("done_err_sticky", err, 1);
        chk("res_count", res_count, exp_res.size());
        chk("res_valid_count", res_q.size(), exp_res.size());
        for (int i = 0; i < exp_res.size(); i++)
            if (i < res_q.size()) chk("res_data", res_q[i], exp_res[i]);
        chk("no_tx_after_data", tx_q.size(), exp_tx.size());
    endtask

    initial begin
        reset = 1'b1;
        load_en = 1'b0;
        load_sel = 1'b0;
        load_addr = 8'd0;
        load_data = 32'd0;
        instr_len = 9'd0;
        data_len = 9'd0;
        start = 1'b0;
        rx_ready = 1'b0;
        rdata = 8'd0;
        ferr = 1'b0;
        tick(3);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_count", res_count, 0);
        reset = 1'b0;
        tick(1);

        for (int i = 0; i < 256; i++) begin
            prog_m[i] = $urandom;
            data_m[i] = $urandom;
        end
        prog_m[0] = 32'h11223344;
        prog_m[1] = 32'h55667788;
        prog_m[2] = 32'h99aabbcc;
        data_m[0] = 32'hdeadbeef;
        data_m[1] = 32'h0badf00d;
        for (int i = 0; i < 256; i++) begin
            load_word(1'b0, i, prog_m[i]);
            load_word(1'b1, i, data_m[i]);
        end

        run_session(3, 2, 1'b1, 8'hA5, 8'h5A);
        run_session(0, 0, 1'b0, 8'h3C, 8'hC3);
        repeat (3)
            run_session($urandom_range(1, 12), $urandom_range(0, 12), 1'($urandom_range(0, 1)),
                        8'($urandom), 8'($urandom));
        run_session(300, 4, 1'b0, 8'h01, 8'h80);

        instr_len = 9'd10;
        data_len = 9'd2;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tx_q.delete();
        send_rx(8'h99, 1'b0);
        wait_tx(8, "pre_reset_bytes");
        reset = 1'b1;
        tick(1);
        chk("mid_reset_tx_start", tx_start, 0);
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_done", done, 0);
        reset = 1'b0;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            prog_m[i] = $urandom;
            data_m[i] = $urandom;
            load_word(1'b0, i, prog_m[i]);
            load_word(1'b1, i, data_m[i]);
        end
        run_session(4, 3, 1'b1, 8'($urandom), 8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
